rsa_mont_exp_core: RTL

- Parametrised successor to the fixed 256-bit RSA core.
- Computes o_a_pow_d = i_a^i_d mod i_n for any operand width W.
- Uses Montgomery multiplication with LSB-first square-and-multiply.
- Adds a busy flag, an abort input and an optional early-exit mode; sits between the host/UART wrapper and the key registers.

---
 rtl/rsa_pkg.sv | 19 +
 rtl/rsa_mont_mul.sv | 65 ++++++
 rtl/rsa_mont_exp_core.sv | 118 +++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared types and constants for the parametrised Montgomery RSA exponentiation core.
package rsa_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_MONT,
    S_UPDATE,
    S_DONE
  } rsa_state_e;

  localparam int RSA_W = 256;

  // Cycles from the accept edge to o_finished for k loop iterations.
  function automatic int rsa_latency(input int w, input int k);
    return w + k * (w + 2) + 1;
  endfunction

endpackage

// File: rtl/rsa_mont_mul.sv
// Radix-2 Montgomery multiplier: o_p = x*y*2^-W mod n in W+1 cycles after i_start.
// Operands are read live and must stay stable until o_done.
module rsa_mont_mul
  import rsa_pkg::*;
#(
  parameter int W     = RSA_W,
  parameter int CNT_W = $clog2(W + 2)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic [W-1:0] i_n,
  output logic [W-1:0] o_p,
  output logic         o_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(W);

  logic [W+1:0]     r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [W-1:0]     r_p;

  logic             w_ybit;
  logic [W+1:0]     w_add;
  logic [W+1:0]     w_sum;
  logic [W+1:0]     w_step;
  logic [W-1:0]     w_red;

  // acc stays below 2n, so acc + x + n fits in W+2 bits.
  always_comb begin
    w_ybit = 1'(i_y >> r_cnt);
    w_add  = r_acc + (w_ybit ? {2'b00, i_x} : '0);
    w_sum  = w_add[0] ? (w_add + {2'b00, i_n}) : w_add;
    w_step = w_sum >> 1;
    w_red  = W'((r_acc >= {2'b00, i_n}) ? (r_acc - {2'b00, i_n}) : r_acc);
  end

  assign o_done = r_busy && (r_cnt == LAST);
  assign o_p    = r_p;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_p    <= '0;
    end else if (i_start) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt == LAST) begin
        r_p    <= w_red;
        r_busy <= 1'b0;
      end else begin
        r_acc <= w_step;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rsa_mont_exp_core.sv
// Modular exponentiation a^d mod n via Montgomery LSB-first square-and-multiply.
// Optional macro RSA_EARLY_EXIT_EN stops once no higher exponent bits remain.
module rsa_mont_exp_core
  import rsa_pkg::*;
#(
  parameter int W     = RSA_W,
  parameter int CNT_W = $clog2(W + 2)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_d,
  input  logic [W-1:0] i_n,
  output logic [W-1:0] o_a_pow_d,
  output logic         o_finished,
  output logic         o_busy
);

  rsa_state_e       r_state, w_next;
  logic [W-1:0]     r_d, r_n, r_m, r_t, r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_finished;

  logic [W:0]       w_t2;
  logic [W-1:0]     w_t2_red;
  logic             w_dbit, w_prep_last, w_last, w_skip;
  logic             w_mm_start, w_done1, w_done2;
  logic [W-1:0]     w_p1, w_p2;

  assign w_t2        = {r_t, 1'b0};
  assign w_t2_red    = W'((w_t2 >= {1'b0, r_n}) ? (w_t2 - {1'b0, r_n}) : w_t2);
  assign w_dbit      = 1'(r_d >> r_cnt);
  assign w_prep_last = (r_cnt == CNT_W'(W - 1));

`ifdef RSA_EARLY_EXIT_EN
  assign w_last = ((r_d >> (r_cnt + CNT_W'(1))) == '0);
  assign w_skip = (r_d == '0);
`else
  assign w_last = (r_cnt == CNT_W'(W - 1));
  assign w_skip = 1'b0;
`endif

  // Multipliers restart on entry to MONT; m and t are stable until UPDATE.
  assign w_mm_start = ((r_state == S_PREP) && w_prep_last && !w_skip) ||
                      ((r_state == S_UPDATE) && !w_last);

  rsa_mont_mul #(.W(W), .CNT_W(CNT_W)) u_mm1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(w_mm_start),
    .i_x(r_m), .i_y(r_t), .i_n(r_n), .o_p(w_p1), .o_done(w_done1)
  );

  rsa_mont_mul #(.W(W), .CNT_W(CNT_W)) u_mm2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(w_mm_start),
    .i_x(r_t), .i_y(r_t), .i_n(r_n), .o_p(w_p2), .o_done(w_done2)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_PREP;
      S_PREP:   if (w_prep_last) w_next = w_skip ? S_DONE : S_MONT;
      S_MONT:   if (w_done1 && w_done2) w_next = S_UPDATE;
      S_UPDATE: w_next = w_last ? S_DONE : S_MONT;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (i_abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_d        <= '0;
      r_n        <= '0;
      r_m        <= '0;
      r_t        <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_finished <= 1'b0;
    end else begin
      r_finished <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_d   <= i_d;
          r_n   <= i_n;
          r_t   <= i_a;
          r_m   <= W'(1);
          r_cnt <= '0;
        end
        S_PREP: begin
          r_t   <= w_t2_red;
          r_cnt <= w_prep_last ? '0 : (r_cnt + CNT_W'(1));
        end
        S_UPDATE: begin
          if (w_dbit) r_m <= w_p1;
          r_t   <= w_p2;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_DONE: if (!i_abort) begin
          r_result   <= r_m;
          r_finished <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_a_pow_d  = r_result;
  assign o_finished = r_finished;
  assign o_busy     = (r_state != S_IDLE);

endmodule
